// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   tx_state_e : transmitter FSM states
//   FRAME_BITS : start + data + stop bits per frame
//   DATA_BITS  : payload bits per frame
//   baud_div() : clock cycles per serial bit (truncated)
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = 8;

   function automatic int baud_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Byte write port of the UART transmitter (valid/ready handshake).
//   wvalid_i : source has a byte to send
//   wready_o : transmitter queue can take a byte
//   wdata_i  : byte to send
// master = byte source, slave = transmitter.
interface uart_tx_buf_if
   import uart_pkg::*;
   ();
   logic                 wvalid_i;
   logic                 wready_o;
   logic [DATA_BITS-1:0] wdata_i;

   modport master (output wvalid_i, output wdata_i, input wready_o);
   modport slave  (input wvalid_i, input wdata_i, output wready_o);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data.
//   clk_i, rst_i : clock, async active-high reset (pointers and count cleared)
//   push_i       : write wdata_i (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   rdata_o      : head entry, valid while !empty_o
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
//   count_o      : occupancy 0..DEPTH
module uart_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [DATA_BITS-1:0]     wdata_i,
   output logic [DATA_BITS-1:0]     rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          count;
   logic                 do_push, do_pop;

   assign full_o  = (count == FULL_CNT);
   assign empty_o = (count == '0);
   assign count_o = count;
   assign rdata_o = mem[rd_ptr];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= wdata_i;
   end

   // Power-of-two depth lets the pointers wrap on their own.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter. Bytes written over the valid/ready port are
// queued in uart_fifo and sent LSB first on txd_o, back to back while the
// queue holds data.
//   clk_i   : clock
//   rst_i   : async active-high reset; line returns high, queue discarded
//   wr      : byte write port (slave side)
//   txd_o   : serial line, idle high, registered
//   busy_o  : frame in flight or queue non-empty
//   count_o : queue occupancy
module uart_tx_buf
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 1_000_000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   uart_tx_buf_if.slave                 wr,
   output logic                         txd_o,
   output logic                         busy_o,
   output logic [$clog2(FIFO_DEPTH):0]  count_o
);
   localparam int DIV   = baud_div(CLK_FREQ, BAUD_RATE);
   localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   if (DIV < 2) begin : g_div_chk
      $error("uart_tx_buf: CLK_FREQ / BAUD_RATE must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("uart_tx_buf: FIFO_DEPTH must be a power of two, at least 2");
   end

   tx_state_e             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic                  txd_q, txd_d;
   logic                  baud_end;
   logic                  pop;

   logic                  fifo_full, fifo_empty;
   logic [DATA_BITS-1:0]  fifo_rdata;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (wr.wvalid_i),
      .pop_i   (pop),
      .wdata_i (wr.wdata_i),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Ready comes from the registered count only, so a pop while full
   // reopens the port on the following cycle.
   assign wr.wready_o = !fifo_full;
   assign count_o     = fifo_count;
   assign busy_o      = (state_q != IDLE) || (fifo_count != '0);
   assign txd_o       = txd_q;

   assign baud_end = (cnt_q == CNT_LAST);

   // Every state change clears the baud counter, so each bit is exactly DIV
   // cycles and frame boundaries never drift. txd_d is the line level for the
   // state being entered, registered on the same edge as the state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      txd_d   = txd_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_rdata;
               state_d = START;
               txd_d   = 1'b0;
            end
         end
         START: begin
            if (baud_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
               txd_d   = shift_q[0];
            end
         end
         DATA: begin
            if (baud_end) begin
               cnt_d = '0;
               if (bit_q == BIT_LAST) begin
                  state_d = STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
                  txd_d   = shift_q[1];
               end
            end
         end
         STOP: begin
            if (baud_end) begin
               cnt_d = '0;
               // Chain straight into the next start bit: no idle gap.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_rdata;
                  state_d = START;
                  txd_d   = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf at DIV=8, FIFO_DEPTH=16. Accepted bytes
// are queued as expected frames; a line-side model samples txd mid-bit,
// decodes each frame and compares it against the queue head.
module tb_uart_tx_buf;
   import uart_pkg::*;

   logic       clk, rst;
   logic       txd, busy;
   logic [4:0] count;
   int         cyc;

   uart_tx_buf_if bus ();

   uart_tx_buf #(.CLK_FREQ(8), .BAUD_RATE(1), .FIFO_DEPTH(16)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .wr      (bus),
      .txd_o   (txd),
      .busy_o  (busy),
      .count_o (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: every accepted byte becomes an expected frame.
   logic [7:0] exp_q[$];
   int         acc_t[$];
   int         nacc = 0;
   always @(posedge clk) begin
      if (rst) exp_q.delete();
      else if (bus.wvalid_i && bus.wready_o) begin
         exp_q.push_back(bus.wdata_i);
         acc_t.push_back(cyc);
         nacc <= nacc + 1;
      end
   end

   // Line-side model: t=0 is the first low cycle of the start bit.
   int start_q[$];
   int dec_cnt = 0;
   bit mon_act = 0;
   initial begin
      int t, st;
      logic [7:0] sh;
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_act = 0;
            continue;
         end
         if (!mon_act) begin
            if (txd == 1'b0) begin
               mon_act = 1;
               t = 0;
               st = cyc;
            end
         end else t++;
         if (mon_act) begin
            if (t == 4) chk("start_bit", int'(txd), 0);
            else if (t >= 12 && t <= 68 && (t % 8) == 4) sh[(t - 12) / 8] = txd;
            else if (t == 76) begin
               chk("stop_bit", int'(txd), 1);
               start_q.push_back(st);
               dec_cnt++;
               if (exp_q.size() == 0) chk("unexpected_frame", int'(sh), -1);
               else chk("frame_data", int'(sh), int'(exp_q.pop_front()));
               mon_act = 0;
            end
         end
      end
   end

   task automatic push(input logic [7:0] b, output int n);
      @(negedge clk);
      bus.wvalid_i = 1'b1;
      bus.wdata_i  = b;
      @(posedge clk);
      #1;
      n = cyc;
      bus.wvalid_i = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0 && !mon_act) return;
      end
      chk("idle_timeout", 0, 1);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      int n, d0, n0, k;
      rst = 1'b1;
      bus.wvalid_i = 1'b0;
      bus.wdata_i  = 8'h00;

      // 1: reset with random inputs
      for (int i = 0; i < 3; i++) begin
         bus.wvalid_i = 1'($urandom_range(0, 1));
         bus.wdata_i  = 8'($urandom);
         @(negedge clk);
         chk("rst_txd", int'(txd), 1);
         chk("rst_wready", int'(bus.wready_o), 1);
         chk("rst_busy", int'(busy), 0);
         chk("rst_count", int'(count), 0);
      end
      rst = 1'b0;
      bus.wvalid_i = 1'b0;
      repeat (2) @(negedge clk);

      // 2: single byte, busy falls 1+80 cycles after accept
      start_q.delete();
      push(8'h55, n);
      wait_cyc(n + 80);
      chk("t2_busy_before_end", int'(busy), 1);
      @(negedge clk);
      chk("t2_busy_at_end", int'(busy), 0);
      wait_idle(200);
      chk("t2_frames", start_q.size(), 1);
      if (start_q.size() >= 1) chk("t2_start_cycle", start_q[0] - n, 1);

      // 3: two back-to-back frames, 160 cycles total
      start_q.delete();
      push(8'hA5, n);
      push(8'h3C, d0);
      wait_cyc(n + 160);
      chk("t3_busy_before_end", int'(busy), 1);
      @(negedge clk);
      chk("t3_busy_at_end", int'(busy), 0);
      wait_idle(300);
      chk("t3_frames", start_q.size(), 2);
      if (start_q.size() >= 2) begin
         chk("t3_start_cycle", start_q[0] - n, 1);
         chk("t3_frame_spacing", start_q[1] - start_q[0], 80);
      end

      // 4 + 6: hold valid from empty; junk data while full must never appear
      n0 = nacc;
      acc_t.delete();
      @(negedge clk);
      bus.wvalid_i = 1'b1;
      bus.wdata_i  = 8'(nacc);
      k = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bus.wready_o) begin
            k = 1;
            break;
         end
         bus.wdata_i = 8'(nacc);
      end
      chk("t4_fill_seen", k, 1);
      chk("t4_accepted_to_full", nacc - n0, 17);
      chk("t4_count_full", int'(count), 16);
      for (int i = 0; i < 250; i++) begin
         if (bus.wready_o) bus.wdata_i = 8'(nacc);
         else bus.wdata_i = 8'($urandom_range(128, 255));
         @(negedge clk);
      end
      bus.wvalid_i = 1'b0;
      chk("t4_accepts_total", nacc - n0, 20);
      if (acc_t.size() >= 20) begin
         chk("t4_accept_gap_a", acc_t[18] - acc_t[17], 80);
         chk("t4_accept_gap_b", acc_t[19] - acc_t[18], 80);
      end
      wait_idle(2500);

      // 5: reset during data bit 3 of 0xF0 with 5 bytes queued
      push(8'hF0, n);
      for (int i = 1; i <= 5; i++) push(8'(i), d0);
      wait_cyc(n + 35);
      chk("t5_count_queued", int'(count), 5);
      chk("t5_txd_bit3", int'(txd), 0);
      rst = 1'b1;
      #1;
      chk("t5_txd_async", int'(txd), 1);
      chk("t5_count_async", int'(count), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      chk("t5_busy_in_rst", int'(busy), 0);
      rst = 1'b0;
      d0 = dec_cnt;
      push(8'h81, n);
      wait_idle(200);
      chk("t5_frames_after_rst", dec_cnt - d0, 1);

      chk("final_scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
